// File: rtl/rns_mod_sub_seq.sv
// Digit-serial modular subtractor: R = (A - B) mod MODULUS, one nibble per cycle,
// LSB first, with a second nibble-serial pass adding MODULUS back when A < B.
module rns_mod_sub_seq #(
  parameter int              WIDTH   = 16,
  parameter longint unsigned MODULUS = 65521
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wrapped
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0]  LAST  = IDXW'(N - 1);
  localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MODULUS);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("rns_mod_sub_seq: WIDTH must be a positive multiple of 4");
  end
  if (MODULUS < 2 || (WIDTH < 64 && MODULUS >= (64'd1 << WIDTH))) begin : g_bad_modulus
    $error("rns_mod_sub_seq: MODULUS must satisfy 2 <= MODULUS < 2**WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [IDXW-1:0]   idx_reg;
  logic              borrow_reg;
  logic              carry_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic              wrapped_reg;

  logic [3:0] a_nibs   [N];
  logic [3:0] b_nibs   [N];
  logic [3:0] m_nibs   [N];
  logic [3:0] res_nibs [N];

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] m_nib;
  logic [3:0] r_nib;
  logic [4:0] diff5;
  logic [4:0] sum5;

  // Split the operands, the modulus and the result into nibble lanes.
  for (genvar gi = 0; gi < N; gi++) begin : g_split
    assign a_nibs[gi]           = a_reg[4*gi +: 4];
    assign b_nibs[gi]           = b_reg[4*gi +: 4];
    assign m_nibs[gi]           = MOD_W[4*gi +: 4];
    assign result[4*gi +: 4]    = res_nibs[gi];
  end

  assign a_nib = a_nibs[idx_reg];
  assign b_nib = b_nibs[idx_reg];
  assign m_nib = m_nibs[idx_reg];
  assign r_nib = res_nibs[idx_reg];

  // Bit 4 of the 5-bit difference is the borrow out; bit 4 of the sum is the carry out.
  assign diff5 = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_reg};
  assign sum5  = {1'b0, r_nib} + {1'b0, m_nib} + {4'b0000, carry_reg};

  // Each result nibble is written only in the cycle its index is active.
  for (genvar gi = 0; gi < N; gi++) begin : g_res
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_nibs[gi] <= 4'h0;
      end else if (idx_reg == IDXW'(gi)) begin
        if (state_reg == SUB) begin
          res_nibs[gi] <= diff5[3:0];
        end else if (state_reg == FIX) begin
          res_nibs[gi] <= sum5[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      idx_reg       <= '0;
      borrow_reg    <= 1'b0;
      carry_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      wrapped_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            borrow_reg   <= 1'b0;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= SUB;
          end
        end
        SUB: begin
          borrow_reg <= diff5[4];
          if (idx_reg == LAST) begin
            idx_reg <= '0;
            if (diff5[4]) begin
              carry_reg   <= 1'b0;
              wrapped_reg <= 1'b1;
              state_reg   <= FIX;
            end else begin
              wrapped_reg   <= 1'b0;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        FIX: begin
          // Carry out of the top nibble falls off: the correction is mod 2**WIDTH.
          carry_reg <= sum5[4];
          if (idx_reg == LAST) begin
            idx_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign wrapped   = wrapped_reg;

endmodule

// File: tb/tb_rns_mod_sub_seq.sv
// Directed and random-pair bench for rns_mod_sub_seq (WIDTH=16, MODULUS=65521).
module tb_rns_mod_sub_seq;

  localparam int WIDTH = 16;
  localparam int MOD   = 65521;
  localparam int N     = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             wrapped;

  int checks;
  int errors;

  rns_mod_sub_seq #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input bit keep_valid);
    check("in_ready_before_accept", in_ready, 1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) check("timeout_out_valid", 0, 1);
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_r, input bit exp_w, input int exp_lat);
    int lat;
    start_op(av, bv, 1'b0);
    wait_result(lat);
    check("latency", lat, exp_lat);
    check("result", result, exp_r);
    check("wrapped", wrapped, exp_w);
    $display("op a=%0d b=%0d -> result=%0d wrapped=%0d latency=%0d", av, bv, result, wrapped, lat);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_accept", out_valid, 0);
    check("in_ready_after_accept", in_ready, 1);
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb, exp_r;
    bit exp_w;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_wrapped", wrapped, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1, T2, T3
    run_op(16'd100, 16'd30, 16'd70, 1'b0, N);
    run_op(16'd30, 16'd100, 16'hFFAB, 1'b1, 2 * N);
    run_op(16'h1234, 16'h1234, 16'd0, 1'b0, N);
    run_op(16'd0, 16'd65520, 16'd1, 1'b1, 2 * N);

    // T4: result held while the consumer stalls
    start_op(16'hFFF0, 16'd0, 1'b0);
    wait_result(lat);
    check("t4_latency", lat, N);
    check("t4_result", result, 16'hFFF0);
    check("t4_wrapped", wrapped, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a        = 16'd7;
      b        = 16'd3;
      @(posedge clk);
      #1;
      check("t4_hold_out_valid", out_valid, 1);
      check("t4_hold_result", result, 16'hFFF0);
      check("t4_hold_in_ready", in_ready, 0);
      $display("stall cycle %0d: out_valid=%0d result=%0h in_ready=%0d", i, out_valid, result, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t4_release_out_valid", out_valid, 0);
    check("t4_release_in_ready", in_ready, 1);

    // T5: asynchronous reset during SUB
    start_op(16'd5, 16'd9, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_result", result, 0);
    check("t5_rst_in_ready", in_ready, 1);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_after_in_ready", in_ready, 1);
    check("t5_after_out_valid", out_valid, 0);
    $display("abort by reset: out_valid=%0d result=%0d in_ready=%0d", out_valid, result, in_ready);
    run_op(16'd9, 16'd5, 16'd4, 1'b0, N);

    // T6: back-to-back random in-range pairs
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      ra = 16'($urandom_range(0, MOD - 1));
      rb = 16'($urandom_range(0, MOD - 1));
      if (ra >= rb) begin
        exp_r = ra - rb;
        exp_w = 1'b0;
      end else begin
        exp_r = 16'(32'(ra) + MOD - 32'(rb));
        exp_w = 1'b1;
      end
      start_op(ra, rb, 1'b1);
      wait_result(lat);
      check("t6_result", result, exp_r);
      check("t6_wrapped", wrapped, exp_w);
      check("t6_latency", lat, exp_w ? 2 * N : N);
      $display("b2b %0d: a=%0d b=%0d -> result=%0d wrapped=%0d latency=%0d",
               k, ra, rb, result, wrapped, lat);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
